e_q_clk_gen: RTL

//  Generates the 6809 E and Q bus clocks from the fast PLL clock, so the FPGA can act as the

---
 rtl/e_clk_pkg.sv | 30 +++
 rtl/quarter_timer.sv | 35 +++
 rtl/e_q_clk_gen.sv | 124 ++++++++++++
 3 files changed

// File: rtl/e_clk_pkg.sv
// Shared types and defaults for the 6809 E/Q clock generator.
// Phase states plus the quarter-to-phase mapping used on o_phase.
package e_clk_pkg;

    typedef enum logic [2:0] {
        IDLE,
        P0,
        P1,
        P2,
        P3,
        STRETCH
    } phase_e;

    localparam int QUARTER_100MHZ_1MHZ = 25;
    localparam int STRETCH_MAX_DEFAULT = 8;

    function automatic logic [1:0] phase_of(input phase_e s);
        logic [1:0] p;
        p = 2'd0;
        unique case (s)
            P1:      p = 2'd1;
            P2:      p = 2'd2;
            P3:      p = 2'd3;
            STRETCH: p = 2'd3;
            default: p = 2'd0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/quarter_timer.sv
// Free-running 0..QUARTER-1 counter with synchronous clear.
// o_tc marks the last i_clk cycle of a quarter.
module quarter_timer #(
    parameter int QUARTER = 25
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    output logic o_tc
);

    localparam int W = (QUARTER > 1) ? $clog2(QUARTER) : 1;
    localparam logic [W-1:0] TC = W'(QUARTER - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + W'(1);
        if (i_clear || cnt_q == TC) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_tc = !i_clear && (cnt_q == TC);

endmodule

// File: rtl/e_q_clk_gen.sv
// 6809 E/Q bus clock source with MRDY stretching and timeout.
// Outputs are flopped from the next state so E/Q never glitch.
module e_q_clk_gen
    import e_clk_pkg::*;
#(
    parameter int QUARTER     = QUARTER_100MHZ_1MHZ,
    parameter int STRETCH_MAX = STRETCH_MAX_DEFAULT
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_run,
    input  logic       i_mrdy_n,
    output logic       o_e,
    output logic       o_q,
    output logic       o_e_rise,
    output logic       o_e_fall,
    output logic [1:0] o_phase,
    output logic       o_stretching,
    output logic       o_timeout
);

    localparam logic [3:0] SMAX = 4'(STRETCH_MAX);

    phase_e     state_q;
    phase_e     state_d;
    logic [3:0] scnt_q;
    logic [3:0] scnt_d;
    logic       tc;
    logic       rise_d;
    logic       fall_d;
    logic       to_d;
    logic       e_d;
    logic       q_d;

    quarter_timer #(
        .QUARTER(QUARTER)
    ) u_qt (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .i_clear(state_q == IDLE),
        .o_tc   (tc)
    );

    always_comb begin
        state_d = state_q;
        scnt_d  = scnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        to_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_run) state_d = P0;
            end
            P0: begin
                if (tc) state_d = P1;
            end
            P1: begin
                if (tc) begin
                    state_d = P2;
                    rise_d  = 1'b1;
                end
            end
            P2: begin
                if (tc) state_d = P3;
            end
            P3: begin
                if (tc) begin
                    if (!i_mrdy_n) begin
                        state_d = STRETCH;
                        scnt_d  = 4'd1;
                    end else begin
                        state_d = i_run ? P0 : IDLE;
                        fall_d  = 1'b1;
                    end
                end
            end
            STRETCH: begin
                if (tc) begin
                    if (!i_mrdy_n && scnt_q < SMAX) begin
                        scnt_d = scnt_q + 4'd1;
                    end else begin
                        // release or forced release at the stretch limit
                        state_d = i_run ? P0 : IDLE;
                        scnt_d  = 4'd0;
                        fall_d  = 1'b1;
                        to_d    = !i_mrdy_n;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                scnt_d  = 4'd0;
            end
        endcase
    end

    assign e_d = (state_d == P2) || (state_d == P3) || (state_d == STRETCH);
    assign q_d = (state_d == P1) || (state_d == P2);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q      <= IDLE;
            scnt_q       <= 4'd0;
            o_e          <= 1'b0;
            o_q          <= 1'b0;
            o_e_rise     <= 1'b0;
            o_e_fall     <= 1'b0;
            o_phase      <= 2'd0;
            o_stretching <= 1'b0;
            o_timeout    <= 1'b0;
        end else begin
            state_q      <= state_d;
            scnt_q       <= scnt_d;
            o_e          <= e_d;
            o_q          <= q_d;
            o_e_rise     <= rise_d;
            o_e_fall     <= fall_d;
            o_phase      <= phase_of(state_d);
            o_stretching <= (state_d == STRETCH);
            o_timeout    <= to_d;
        end
    end

endmodule
